// File: rtl/rgb_pwm_fader.sv
// Three-channel period-aligned PWM generator with an optional linear fade engine.
// Levels ramp one code per step toward their targets; duty latches only at period end.
module rgb_pwm_fader #(
    parameter int unsigned PWM_BITS = 6,
    parameter bit          FADE     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step,
    input  logic                    ld,
    input  logic [3*PWM_BITS-1:0]   tgt,
    output logic [2:0]              pwm,
    output logic [3*PWM_BITS-1:0]   level,
    output logic                    busy,
    output logic                    wrap
);

    localparam int unsigned NCH = 3;
    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0]           cnt, cnt_nxt;
    logic [NCH-1:0][PWM_BITS-1:0]  duty, duty_nxt;
    logic [NCH-1:0][PWM_BITS-1:0]  lvl, lvl_nxt;
    logic [NCH-1:0][PWM_BITS-1:0]  tgt_r, tgt_nxt;
    logic [NCH-1:0][PWM_BITS-1:0]  tgt_in;
    logic [NCH-1:0]                pwm_nxt;
    logic                          busy_nxt;
    logic                          wrap_nxt;

    assign tgt_in = tgt;
    assign level  = lvl;

    // Next-state for counter, duty latch, fade engine and the registered outputs
    always_comb begin
        cnt_nxt  = cnt + PWM_BITS'(1);
        duty_nxt = (cnt == CNT_MAX) ? lvl : duty;
        lvl_nxt  = lvl;
        tgt_nxt  = tgt_r;

        // Step compares against the pre-load target; a same-cycle ld lands afterwards
        if (FADE && step) begin
            for (int i = 0; i < NCH; i++) begin
                if (lvl[i] < tgt_r[i]) begin
                    lvl_nxt[i] = lvl[i] + PWM_BITS'(1);
                end else if (lvl[i] > tgt_r[i]) begin
                    lvl_nxt[i] = lvl[i] - PWM_BITS'(1);
                end
            end
        end

        if (ld) begin
            tgt_nxt = tgt_in;
            if (!FADE) begin
                lvl_nxt = tgt_in;
            end
        end

        // Full-scale code keeps the output high for the whole period
        for (int i = 0; i < NCH; i++) begin
            pwm_nxt[i] = (duty_nxt[i] == CNT_MAX) || (cnt_nxt < duty_nxt[i]);
        end

        busy_nxt = (lvl_nxt != tgt_nxt);
        wrap_nxt = (cnt_nxt == CNT_MAX);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            duty  <= '0;
            lvl   <= '0;
            tgt_r <= '0;
            pwm   <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            duty  <= duty_nxt;
            lvl   <= lvl_nxt;
            tgt_r <= tgt_nxt;
            pwm   <= pwm_nxt;
            busy  <= busy_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader: one FADE=0 and one FADE=1 instance share stimulus,
// each checked every cycle against a period/arithmetic model of the fader.
module tb_rgb_pwm_fader;

    localparam int unsigned N   = 6;
    localparam int          TOP = 63;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          step = 1'b0;
    logic          ld = 1'b0;
    logic [17:0]   tgt = '0;

    logic [2:0]    pwm0, pwm1;
    logic [17:0]   level0, level1;
    logic          busy0, busy1, wrap0, wrap1;

    rgb_pwm_fader #(.PWM_BITS(N), .FADE(1'b0)) u_inst (
        .clk(clk), .rst_n(rst_n), .step(step), .ld(ld), .tgt(tgt),
        .pwm(pwm0), .level(level0), .busy(busy0), .wrap(wrap0)
    );

    rgb_pwm_fader #(.PWM_BITS(N), .FADE(1'b1)) u_fade (
        .clk(clk), .rst_n(rst_n), .step(step), .ld(ld), .tgt(tgt),
        .pwm(pwm1), .level(level1), .busy(busy1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time within period, latched brightness, level and target per channel
    int m_t;
    int m_duty [2][3];
    int m_lvl  [2][3];
    int m_tg   [2][3];

    logic [22:0] q0[$];
    logic [22:0] q1[$];

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got pwm=%b level=%h busy=%b wrap=%b, expected pwm=%b level=%h busy=%b wrap=%b",
                     name, $time, act[22:20], act[19:2], act[1], act[0],
                     exp[22:20], exp[19:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_clear();
        m_t = 0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) begin
                m_duty[k][i] = 0; m_lvl[k][i] = 0; m_tg[k][i] = 0;
            end
    endtask

    function automatic logic [22:0] model_expect(input int k);
        logic [2:0]  p;
        logic [17:0] lv;
        logic        b;
        b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p[i] = (m_duty[k][i] == TOP) || (m_t < m_duty[k][i]);
            lv[i*6 +: 6] = 6'(m_lvl[k][i]);
            if (m_lvl[k][i] != m_tg[k][i]) b = 1'b1;
        end
        return {p, lv, b, (m_t == TOP)};
    endfunction

    // Advance the model across one clock edge with the given inputs
    task automatic model_edge(input logic s, input logic l, input logic [17:0] t);
        logic [17:0] tv;
        tv = t;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (m_t == TOP) m_duty[k][i] = m_lvl[k][i];
                if (k == 1 && s) begin
                    if (m_lvl[k][i] < m_tg[k][i]) m_lvl[k][i] = m_lvl[k][i] + 1;
                    else if (m_lvl[k][i] > m_tg[k][i]) m_lvl[k][i] = m_lvl[k][i] - 1;
                end
                if (l) begin
                    m_tg[k][i] = int'(tv[i*6 +: 6]);
                    if (k == 0) m_lvl[k][i] = m_tg[k][i];
                end
            end
        end
        m_t = (m_t + 1) % 64;
    endtask

    task automatic tick(input logic s, input logic l, input logic [17:0] t);
        step = s; ld = l; tgt = t;
        @(posedge clk);
        model_edge(s, l, t);
        q0.push_back(model_expect(0));
        q1.push_back(model_expect(1));
        #1;
        step = 1'b0; ld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, tgt);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, tgt);
            tick(1'b0, 1'b0, tgt);
        end
    endtask

    function automatic logic [17:0] pack3(input int c2, input int c1, input int c0);
        return {6'(c2), 6'(c1), 6'(c0)};
    endfunction

    // Monitor: compare every cycle's DUT outputs against the queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (q0.size() > 0) check("inst_cycle", {pwm0, level0, busy0, wrap0}, q0.pop_front());
            if (q1.size() > 0) check("fade_cycle", {pwm1, level1, busy1, wrap1}, q1.pop_front());
        end
    end

    function automatic int rand_code();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TOP;
        return int'($urandom_range(0, TOP));
    endfunction

    initial begin
        model_clear();
        #1;
        check("reset_inst", {pwm0, level0, busy0, wrap0}, '0);
        check("reset_fade", {pwm1, level1, busy1, wrap1}, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset: zeros everywhere, wrap once per 64 cycles
        idle(200);

        // ch0 = 16: instant on FADE=0, target only on FADE=1
        tick(1'b0, 1'b1, pack3(0, 0, 16));
        idle(140);

        // Full and zero scale
        tick(1'b0, 1'b1, pack3(63, 0, 16));
        idle(200);

        // Ramp ch1 0 -> 5 on FADE=1, plus an extra step that must hold
        tick(1'b0, 1'b1, pack3(0, 0, 0));
        steps(70);
        tick(1'b0, 1'b1, pack3(0, 5, 0));
        steps(6);
        idle(70);

        // ch0 to 10, then retarget 7 with a coincident step, then down to 0
        tick(1'b0, 1'b1, pack3(0, 5, 10));
        steps(10);
        tick(1'b1, 1'b1, pack3(0, 5, 7));
        steps(3);
        idle(64);
        tick(1'b0, 1'b1, pack3(0, 5, 0));
        steps(12);
        idle(64);

        // Randomized loads and steps
        for (int i = 0; i < 3000; i++) begin
            logic s, l;
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 39) == 0);
            if (l) tick(s, 1'b1, pack3(rand_code(), rand_code(), rand_code()));
            else   tick(s, 1'b0, tgt);
        end

        // Mid-fade asynchronous reset at cnt = 20
        tick(1'b0, 1'b1, pack3(63, 40, 63));
        idle(70);
        tick(1'b0, 1'b1, pack3(0, 0, 0));
        tick(1'b0, 1'b1, pack3(63, 40, 63));
        for (int i = 0; i < 64 && m_t != 20; i++) tick(1'b1, 1'b0, tgt);
        check("cnt20_reached", {22'd0, (m_t == 20)}, 23'd1);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        model_clear();
        #1;
        check("async_rst_inst", {pwm0, level0, busy0, wrap0}, '0);
        check("async_rst_fade", {pwm1, level1, busy1, wrap1}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(140);

        @(negedge clk);
        #1;
        check("queues_drained", 23'(q0.size() + q1.size()), 23'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
